// File: rtl/slip_decoder.sv
// slip_decoder
// Decodes a SLIP-framed byte stream (as delivered by a UART receiver) into
// AXI-Stream payload beats. A one-byte hold register delays each payload byte
// until the next non-escape byte arrives. This lets the final byte of a frame
// carry tlast when the closing END is seen.
//
// Ports
//   clk                sole clock, rising edge
//   rst_n              asynchronous, active-low reset
//   input_axi_tdata    received byte
//   input_axi_tvalid   received byte valid
//   input_axi_tready   byte accepted when high together with tvalid
//   output_axi_tdata   decoded payload byte
//   output_axi_tvalid  output beat valid
//   output_axi_tready  downstream accepts the beat
//   output_axi_tlast   last byte of a decoded frame
//   output_axi_tuser   frame bad (meaningful only with tlast=1)
//   busy               frame partially received (hold full or escape pending)
//   escape_error       one-cycle pulse on an invalid escape sequence
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. A producer never withdraws or changes a beat while valid is high and
// ready is low. Ready may depend on valid, but valid never depends on ready.

module slip_decoder (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] input_axi_tdata,
   input  logic       input_axi_tvalid,
   output logic       input_axi_tready,
   output logic [7:0] output_axi_tdata,
   output logic       output_axi_tvalid,
   input  logic       output_axi_tready,
   output logic       output_axi_tlast,
   output logic       output_axi_tuser,
   output logic       busy,
   output logic       escape_error
);

   localparam logic [7:0] SLIP_END     = 8'hC0;
   localparam logic [7:0] SLIP_ESC     = 8'hDB;
   localparam logic [7:0] SLIP_ESC_END = 8'hDC;
   localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_ESCAPE = 1'b1
   } state_t;

   state_t     state;
   logic       hold_valid;
   logic [7:0] hold_data;
   logic       bad;

   logic       in_fire;
   logic       out_fire;

   // Classification of the byte currently offered, given the current state.
   logic       is_end;
   logic       go_escape;
   logic       is_payload;
   logic [7:0] payload_byte;
   logic       esc_err;
   logic       set_bad;

   // Input is taken only when the output register is free or is being emptied
   // this cycle, so a stalled beat blocks acceptance.
   assign input_axi_tready = output_axi_tready | ~output_axi_tvalid;
   assign in_fire          = input_axi_tvalid & input_axi_tready;
   assign out_fire         = output_axi_tvalid & output_axi_tready;

   always_comb begin
      is_end       = 1'b0;
      go_escape    = 1'b0;
      is_payload   = 1'b0;
      payload_byte = input_axi_tdata;
      esc_err      = 1'b0;
      set_bad      = 1'b0;
      case (state)
         ST_NORMAL: begin
            if (input_axi_tdata == SLIP_END) begin
               is_end = 1'b1;
            end else if (input_axi_tdata == SLIP_ESC) begin
               go_escape = 1'b1;
            end else begin
               is_payload = 1'b1;
            end
         end
         ST_ESCAPE: begin
            if (input_axi_tdata == SLIP_END) begin
               // Frame closed in the middle of an escape: terminate it as bad.
               is_end  = 1'b1;
               esc_err = 1'b1;
            end else if (input_axi_tdata == SLIP_ESC_END) begin
               is_payload   = 1'b1;
               payload_byte = SLIP_END;
            end else if (input_axi_tdata == SLIP_ESC_ESC) begin
               is_payload   = 1'b1;
               payload_byte = SLIP_ESC;
            end else begin
               // Unknown escape: keep the raw byte but mark the frame bad.
               is_payload = 1'b1;
               esc_err    = 1'b1;
               set_bad    = 1'b1;
            end
         end
         default: begin
            is_payload = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= ST_NORMAL;
         hold_valid        <= 1'b0;
         hold_data         <= 8'h00;
         bad               <= 1'b0;
         output_axi_tvalid <= 1'b0;
         output_axi_tdata  <= 8'h00;
         output_axi_tlast  <= 1'b0;
         output_axi_tuser  <= 1'b0;
         busy              <= 1'b0;
         escape_error      <= 1'b0;
      end else begin
         escape_error <= 1'b0;
         if (out_fire) begin
            output_axi_tvalid <= 1'b0;
         end
         if (in_fire) begin
            escape_error <= esc_err;
            if (is_end) begin
               if (hold_valid) begin
                  output_axi_tvalid <= 1'b1;
                  output_axi_tdata  <= hold_data;
                  output_axi_tlast  <= 1'b1;
                  output_axi_tuser  <= bad | esc_err;
               end
               hold_valid <= 1'b0;
               bad        <= 1'b0;
               state      <= ST_NORMAL;
               busy       <= 1'b0;
            end else if (go_escape) begin
               state <= ST_ESCAPE;
               busy  <= 1'b1;
            end else if (is_payload) begin
               if (hold_valid) begin
                  output_axi_tvalid <= 1'b1;
                  output_axi_tdata  <= hold_data;
                  output_axi_tlast  <= 1'b0;
                  output_axi_tuser  <= 1'b0;
               end
               hold_data  <= payload_byte;
               hold_valid <= 1'b1;
               bad        <= bad | set_bad;
               state      <= ST_NORMAL;
               busy       <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_slip_decoder.sv
// Directed testbench for slip_decoder. Beats are recorded as {tuser, tlast, tdata}.
module tb_slip_decoder;

   logic       clk;
   logic       rst_n;
   logic [7:0] in_tdata;
   logic       in_tvalid;
   logic       in_tready;
   logic [7:0] out_tdata;
   logic       out_tvalid;
   logic       out_tready;
   logic       out_tlast;
   logic       out_tuser;
   logic       busy;
   logic       escape_error;

   int total;
   int bad;
   int err_count;
   bit busy_seen;
   bit rand_mode;
   bit prev_stall;
   logic [9:0] prev_beat;

   logic [9:0] exp_q[$];
   logic [9:0] got_q[$];

   slip_decoder dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .input_axi_tdata   (in_tdata),
      .input_axi_tvalid  (in_tvalid),
      .input_axi_tready  (in_tready),
      .output_axi_tdata  (out_tdata),
      .output_axi_tvalid (out_tvalid),
      .output_axi_tready (out_tready),
      .output_axi_tlast  (out_tlast),
      .output_axi_tuser  (out_tuser),
      .busy              (busy),
      .escape_error      (escape_error)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Downstream ready: held high, or randomised each cycle when rand_mode is set.
   always @(posedge clk) begin
      #1;
      out_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: samples on the falling edge, between active edges.
   always @(negedge clk) begin
      if (rst_n) begin
         if (busy) busy_seen = 1'b1;
         if (escape_error) err_count++;
         if (prev_stall) begin
            check("stall_hold_valid", 32'(out_tvalid), 32'd1);
            check("stall_hold_beat", 32'({out_tuser, out_tlast, out_tdata}), 32'(prev_beat));
         end
         if (out_tvalid && !out_tready) begin
            check("stall_blocks_input", 32'(in_tready), 32'd0);
         end
         if (out_tvalid && out_tready) got_q.push_back({out_tuser, out_tlast, out_tdata});
         prev_stall = out_tvalid && !out_tready;
         prev_beat  = {out_tuser, out_tlast, out_tdata};
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Driver: called just after a rising edge; returns just after the edge
   // on which the byte was accepted.
   task automatic send_byte(input logic [7:0] b);
      bit done;
      done      = 1'b0;
      in_tdata  = b;
      in_tvalid = 1'b1;
      for (int n = 0; n < 1000 && !done; n++) begin
         @(negedge clk);
         if (in_tready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      in_tvalid = 1'b0;
      check("send_timeout", 32'(done), 32'd1);
   endtask

   task automatic drain_and_compare(input string tag);
      int n;
      rand_mode = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check({tag, "_beat"}, 32'(got_q[i]), 32'(exp_q[i]));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tvalid"}, 32'(out_tvalid), 32'd0);
      check({tag, "_tdata"}, 32'(out_tdata), 32'd0);
      check({tag, "_tlast"}, 32'(out_tlast), 32'd0);
      check({tag, "_tuser"}, 32'(out_tuser), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_escerr"}, 32'(escape_error), 32'd0);
   endtask

   initial begin
      total = 0; bad = 0; err_count = 0; busy_seen = 1'b0;
      rand_mode = 1'b0; prev_stall = 1'b0; prev_beat = '0;
      in_tdata = 8'h00; in_tvalid = 1'b0; out_tready = 1'b1;
      rst_n = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      check("reset_in_tready", 32'(in_tready), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // C0 01 02 03 C0, with latency and busy checks
      err_count = 0;
      send_byte(8'hC0);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      @(negedge clk);
      check("busy_mid_frame", 32'(busy), 32'd1);
      @(posedge clk); #1;
      send_byte(8'hC0);
      @(negedge clk);
      check("last_latency_tvalid", 32'(out_tvalid), 32'd1);
      check("last_latency_beat", 32'({out_tuser, out_tlast, out_tdata}), 32'h103);
      check("busy_after_end", 32'(busy), 32'd0);
      exp_q.push_back(10'h001);
      exp_q.push_back(10'h002);
      exp_q.push_back(10'h103);
      drain_and_compare("basic");
      check("basic_escerr", 32'(err_count), 32'd0);

      // 05 DB DC DB DD C0 -> 05, C0, DB(last)
      send_byte(8'h05);
      send_byte(8'hDB);
      send_byte(8'hDC);
      send_byte(8'hDB);
      send_byte(8'hDD);
      send_byte(8'hC0);
      exp_q.push_back(10'h005);
      exp_q.push_back(10'h0C0);
      exp_q.push_back(10'h1DB);
      drain_and_compare("escape");
      check("escape_escerr", 32'(err_count), 32'd0);

      // C0 C0 C0 -> nothing, busy never high
      busy_seen = 1'b0;
      send_byte(8'hC0);
      send_byte(8'hC0);
      send_byte(8'hC0);
      drain_and_compare("empty");
      check("empty_busy_seen", 32'(busy_seen), 32'd0);

      // 11 DB 22 33 C0 -> bad frame; then 44 C0 is clean
      err_count = 0;
      send_byte(8'h11);
      send_byte(8'hDB);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'hC0);
      exp_q.push_back(10'h011);
      exp_q.push_back(10'h022);
      exp_q.push_back(10'h333);
      drain_and_compare("bad_esc");
      check("bad_esc_escerr", 32'(err_count), 32'd1);
      send_byte(8'h44);
      send_byte(8'hC0);
      exp_q.push_back(10'h144);
      drain_and_compare("after_bad");
      check("after_bad_escerr", 32'(err_count), 32'd1);

      // END inside an escape: 55 DB C0 -> 55(last, bad); DB C0 -> nothing
      err_count = 0;
      send_byte(8'h55);
      send_byte(8'hDB);
      send_byte(8'hC0);
      send_byte(8'hDB);
      send_byte(8'hC0);
      exp_q.push_back(10'h355);
      drain_and_compare("esc_end");
      check("esc_end_escerr", 32'(err_count), 32'd2);
      send_byte(8'h66);
      send_byte(8'hC0);
      exp_q.push_back(10'h166);
      drain_and_compare("esc_end_next");

      // 0x00..0x3F then C0 under random backpressure
      rand_mode = 1'b1;
      for (int i = 0; i < 64; i++) begin
         send_byte(8'(i));
         exp_q.push_back((i == 63) ? 10'h13F : 10'(i));
      end
      send_byte(8'hC0);
      drain_and_compare("backpressure");

      // reset mid-frame after 7A 7B
      send_byte(8'h7A);
      send_byte(8'h7B);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("mid_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      got_q.delete();
      send_byte(8'h01);
      send_byte(8'hC0);
      exp_q.push_back(10'h101);
      drain_and_compare("post_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/slip_decoder.md
SLIP_DECODER -- requirements
Module: slip_decoder

Interface
REQ-001 The block SHALL have no parameters; the data width SHALL be fixed at 8 bits.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 input_axi_tdata  input  8  received byte from the UART receiver.
REQ-005 input_axi_tvalid  input  1  input byte valid.
REQ-006 input_axi_tready  output  1  input byte accepted when high with tvalid.
REQ-007 output_axi_tdata  output  8  decoded payload byte.
REQ-008 output_axi_tvalid  output  1  output beat valid.
REQ-009 output_axi_tready  input  1  downstream accepts beat.
REQ-010 output_axi_tlast  output  1  last byte of a decoded frame.
REQ-011 output_axi_tuser  output  1  frame bad; meaningful only with tlast=1.
REQ-012 busy  output  1  high while a frame is partially received (hold register full or escape pending).
REQ-013 escape_error  output  1  one-cycle pulse on an invalid escape sequence.

Function
REQ-014 Codes SHALL be: END=0xC0, ESC=0xDB, ESC_END=0xDC, ESC_ESC=0xDD.
REQ-015 State machine SHALL have two states: NORMAL and ESCAPE.
REQ-016 The block SHALL keep a one-byte hold register (hold_valid, hold_data) and a sticky bad flag so tlast can be attached to the final payload byte.
REQ-017 The block SHALL register all outputs; input_axi_tready SHALL equal output_axi_tready OR NOT output_axi_tvalid.
REQ-018 A beat SHALL leave the output register when output_axi_tvalid and output_axi_tready are both high; tvalid, tdata, tlast and tuser SHALL stay stable until then.
REQ-019 NORMAL, accepted byte not END/ESC: if hold_valid, emit hold_data with tlast=0, tuser=0; load the byte into the hold register.
REQ-020 NORMAL, accepted ESC: go to ESCAPE; emit nothing.
REQ-021 NORMAL, accepted END with hold_valid: emit hold_data with tlast=1, tuser=bad; clear hold_valid and bad.
REQ-022 NORMAL, accepted END without hold_valid (empty frame or back-to-back END): emit nothing; clear bad.
REQ-023 ESCAPE, accepted ESC_END or ESC_ESC: decoded byte 0xC0 or 0xDB, handled as in REQ-019; return to NORMAL.
REQ-024 ESCAPE, accepted END: pulse escape_error; terminate as in REQ-021 but with tuser=1; if hold empty, emit nothing; clear bad; return to NORMAL.
REQ-025 ESCAPE, accepted any other byte (including ESC): pulse escape_error; set bad; handle the raw byte as in REQ-019; return to NORMAL.
REQ-026 Latency: a payload byte SHALL appear on the output one cycle after acceptance of the following non-ESC byte; a frame's final byte SHALL appear one cycle after acceptance of its END.
REQ-027 With continuous input and output_axi_tready held high, throughput SHALL be one input byte per cycle.
REQ-028 Beats SHALL never be dropped or duplicated under any tready pattern; a beat held under backpressure SHALL block input acceptance.

Reset
REQ-029 rst_n low SHALL immediately force output_axi_tvalid=0, output_axi_tdata=0, output_axi_tlast=0, output_axi_tuser=0, escape_error=0, busy=0, state=NORMAL, hold_valid=0, bad=0.
REQ-030 Reset mid-frame SHALL discard the partial frame; the first post-reset bytes SHALL be decoded as the start of a new frame.

Verification
REQ-031 Input C0 01 02 03 C0, tready=1 -> beats 01, 02, 03(tlast=1, tuser=0); escape_error never pulses.
REQ-032 Input 05 DB DC DB DD C0 -> beats 05, C0, DB(tlast=1, tuser=0).
REQ-033 Input C0 C0 C0 -> no output beats; busy stays 0.
REQ-034 Input 11 DB 22 33 C0 -> escape_error pulses once; beats 11, 22, 33(tlast=1, tuser=1); next frame 44 C0 -> 44(tlast=1, tuser=0).
REQ-035 Input 0x00..0x3F then C0 with output_axi_tready toggling randomly -> all 64 bytes in order, only the last has tlast=1; input_axi_tready low whenever a beat stalls.
REQ-036 Drive rst_n low after 7A 7B accepted, release, then input 01 C0 -> output only 01(tlast=1, tuser=0); all outputs 0 during reset.
